// File: rtl/fc_control_seq.sv
// fc_control_seq: issue/drain sequencer for the fully-connected layer datapath.
// Streams INNEURON/2 dual-port read beats per output group, delays the
// beat tags through a RD_LATENCY-deep pipeline to line them up with RAM data,
// muxes the selected input-neuron bank onto the MAC operands and strobes
// write_en once each group's accumulation is final.
// Optional build macro: FC_CTRL_HOLD_EN (enables the hold stall input).
module fc_control_seq #(
    parameter int INNEURON      = 8,
    parameter int OUTNEURON     = 4,
    parameter int PI            = 2,
    parameter int PO            = 2,
    parameter int DATA_WIDTH_FC = 16,
    parameter int RD_LATENCY    = 1,
    parameter int IN_CNT_W      = 8,
    parameter int OUT_CNT_W     = 8
) (
    input  logic                        clock,
    input  logic                        reset_n,
    input  logic                        start,
    input  logic                        hold,
    input  logic [DATA_WIDTH_FC*PI-1:0] in_neuron_q_a_all,
    input  logic [DATA_WIDTH_FC*PI-1:0] in_neuron_q_b_all,
    output logic                        in_neuron_rden,
    output logic                        fc_weight_rden,
    output logic                        addr_clear,
    output logic                        addr_en,
    output logic                        enable_mult,
    output logic                        accum_sload,
    output logic [DATA_WIDTH_FC-1:0]    in_neuron_q_a_mux,
    output logic [DATA_WIDTH_FC-1:0]    in_neuron_q_b_mux,
    output logic [IN_CNT_W-1:0]         count_sload,
    output logic [OUT_CNT_W-1:0]        count_out,
    output logic                        write_en,
    output logic                        busy,
    output logic                        done
);

    localparam int unsigned K = INNEURON / 2;
    localparam int unsigned G = OUTNEURON / PO;
    localparam int unsigned B = K / PI;
    localparam int unsigned PW = RD_LATENCY * IN_CNT_W;

    localparam logic [IN_CNT_W-1:0]  CNT_LAST = IN_CNT_W'(K - 1);
    localparam logic [OUT_CNT_W-1:0] GRP_LAST = OUT_CNT_W'(G - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t state, state_nxt;

    logic hold_act;

`ifdef FC_CTRL_HOLD_EN
    assign hold_act = hold;
`else
    logic unused_hold;
    assign unused_hold = hold;
    assign hold_act    = 1'b0;
`endif

    // Issue-side control decodes
    logic start_acc;
    logic issue;
    logic beat_last_grp;
    logic beat_last_all;

    assign start_acc     = start && !hold_act && (state == S_IDLE || state == S_DONE);
    assign issue         = (state == S_RUN);
    assign beat_last_grp = (count_sload == CNT_LAST);
    assign beat_last_all = beat_last_grp && (count_out == GRP_LAST);

    // Beat-tag pipeline: bit/slice 0 is the newest entry, the top is the MAC side
    logic [RD_LATENCY-1:0] pipe_valid;
    logic [RD_LATENCY-1:0] pipe_last;
    logic [PW-1:0]         pipe_cnt;
    logic                  write_en_q;

    logic                  mac_valid;
    logic                  mac_last;
    logic [IN_CNT_W-1:0]   mac_cnt;

    assign mac_valid = pipe_valid[RD_LATENCY-1];
    assign mac_last  = pipe_last[RD_LATENCY-1];
    assign mac_cnt   = pipe_cnt[PW-1 -: IN_CNT_W];

    // State register
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode; DRAIN waits for an empty pipeline and the final write strobe
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE, S_DONE: begin
                if (start_acc) state_nxt = S_RUN;
            end
            S_RUN: begin
                if (!hold_act && beat_last_all) state_nxt = S_DRAIN;
            end
            S_DRAIN: begin
                if (!hold_act && pipe_valid == '0 && write_en_q) state_nxt = S_DONE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Counters, beat-tag pipeline, write strobe and address-clear pulse
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count_sload <= '0;
            count_out   <= '0;
            pipe_valid  <= '0;
            pipe_last   <= '0;
            pipe_cnt    <= '0;
            write_en_q  <= 1'b0;
            addr_clear  <= 1'b0;
        end else begin
            addr_clear <= start_acc;
            if (start_acc) begin
                count_sload <= '0;
                count_out   <= '0;
            end else if (issue && !hold_act) begin
                if (beat_last_grp) begin
                    count_sload <= '0;
                    count_out   <= count_out + OUT_CNT_W'(1);
                end else begin
                    count_sload <= count_sload + IN_CNT_W'(1);
                end
            end
            if (!hold_act) begin
                pipe_valid <= (pipe_valid << 1) | RD_LATENCY'(issue);
                pipe_last  <= (pipe_last << 1) | RD_LATENCY'(issue && beat_last_grp);
                pipe_cnt   <= (pipe_cnt << IN_CNT_W) | PW'(count_sload);
                write_en_q <= mac_valid && mac_last;
            end
        end
    end

    // Moore outputs plus MAC-side strobes; hold masks every strobe
    always_comb begin
        in_neuron_rden = (state == S_RUN) && !hold_act;
        fc_weight_rden = in_neuron_rden;
        addr_en        = in_neuron_rden;
        enable_mult    = mac_valid && !hold_act;
        accum_sload    = mac_valid && (mac_cnt == '0) && !hold_act;
        write_en       = write_en_q && !hold_act;
        busy           = (state == S_RUN) || (state == S_DRAIN);
        done           = (state == S_DONE);
    end

    // Bank select: beats 0..B-1 read bank 0, B..2B-1 bank 1, and so on
    always_comb begin
        in_neuron_q_a_mux = '0;
        in_neuron_q_b_mux = '0;
        if (mac_valid) begin
            for (int unsigned p = 0; p < PI; p++) begin
                if ((int'(mac_cnt) / B) == p) begin
                    in_neuron_q_a_mux = in_neuron_q_a_all[p*DATA_WIDTH_FC +: DATA_WIDTH_FC];
                    in_neuron_q_b_mux = in_neuron_q_b_all[p*DATA_WIDTH_FC +: DATA_WIDTH_FC];
                end
            end
        end
    end

endmodule

// File: tb/tb_fc_control_seq.sv
// Bench for fc_control_seq: table-driven per-cycle vectors through a scoreboard
// queue on the default configuration, plus hand-written sequences for async
// reset mid-run and an RD_LATENCY=3 / PI=1 / INNEURON=6 instance.
module tb_fc_control_seq;

    localparam int K     = 4;
    localparam int G     = 2;
    localparam int NROWS = 14;

    typedef struct {
        bit        start;
        bit        hold;
        bit        rden;
        bit        clr;
        bit        en;
        bit        acc;
        bit        wr;
        bit        done;
        bit        busy;
        bit [7:0]  cs;
        bit [7:0]  co;
        bit [15:0] ma;
        bit [15:0] mb;
    } vec_t;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        start;
    logic        hold;
    logic [31:0] qa_all;
    logic [31:0] qb_all;
    logic        in_neuron_rden, fc_weight_rden, addr_clear, addr_en;
    logic        enable_mult, accum_sload, write_en, busy, done;
    logic [15:0] ma, mb;
    logic [7:0]  count_sload, count_out;

    logic        start3;
    logic [15:0] qa3, qb3;
    logic        rden3, wrden3, clr3, aen3, en3, acc3, wr3, busy3, done3;
    logic [15:0] ma3, mb3;
    logic [7:0]  cs3, co3;

    int   n_cmp = 0;
    int   n_bad = 0;
    vec_t sb_q[$];
    vec_t nom_tbl[NROWS];
    vec_t rst_tbl[NROWS];
    vec_t hold_tbl[NROWS];

    always #5 clock = ~clock;

    fc_control_seq dut (
        .clock(clock), .reset_n(reset_n), .start(start), .hold(hold),
        .in_neuron_q_a_all(qa_all), .in_neuron_q_b_all(qb_all),
        .in_neuron_rden(in_neuron_rden), .fc_weight_rden(fc_weight_rden),
        .addr_clear(addr_clear), .addr_en(addr_en),
        .enable_mult(enable_mult), .accum_sload(accum_sload),
        .in_neuron_q_a_mux(ma), .in_neuron_q_b_mux(mb),
        .count_sload(count_sload), .count_out(count_out),
        .write_en(write_en), .busy(busy), .done(done)
    );

    fc_control_seq #(.INNEURON(6), .PI(1), .RD_LATENCY(3)) dut3 (
        .clock(clock), .reset_n(reset_n), .start(start3), .hold(hold),
        .in_neuron_q_a_all(qa3), .in_neuron_q_b_all(qb3),
        .in_neuron_rden(rden3), .fc_weight_rden(wrden3),
        .addr_clear(clr3), .addr_en(aen3),
        .enable_mult(en3), .accum_sload(acc3),
        .in_neuron_q_a_mux(ma3), .in_neuron_q_b_mux(mb3),
        .count_sload(cs3), .count_out(co3),
        .write_en(wr3), .busy(busy3), .done(done3)
    );

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    // Expected outputs after edge n of a nominal run (start sampled at edge 0)
    function automatic vec_t nominal(input int n);
        vec_t v;
        int   m;
        v      = '{default: 0};
        m      = n - 1;
        v.rden = (n >= 0 && n <= G*K - 1);
        v.clr  = (n == 0);
        v.en   = (n >= 1 && n <= G*K);
        v.acc  = v.en && (m % K == 0);
        v.wr   = (n == K + 1) || (n == 2*K + 1);
        v.done = (n >= G*K + 2);
        v.busy = !v.done;
        v.cs   = (n <= G*K - 1) ? 8'(n % K) : 8'd0;
        v.co   = (n <= G*K - 1) ? 8'(n / K) : 8'(G);
        if (v.en) begin
            v.ma = (m % K < 2) ? 16'h0011 : 16'h0022;
            v.mb = (m % K < 2) ? 16'h0033 : 16'h0044;
        end
        return v;
    endfunction

    // Expected outputs with hold sampled high at edges 2 and 3
    function automatic vec_t hold_vec(input int n);
        vec_t v;
`ifdef FC_CTRL_HOLD_EN
        if (n < 2) begin
            v = nominal(n);
        end else if (n <= 3) begin
            v      = nominal(1);
            v.rden = 1'b0;
            v.en   = 1'b0;
            v.acc  = 1'b0;
            v.wr   = 1'b0;
            v.clr  = 1'b0;
        end else begin
            v = nominal(n - 2);
        end
`else
        v = nominal(n);
`endif
        return v;
    endfunction

    task automatic check_zero(input string tag);
        check({tag, ".rden"},  32'(in_neuron_rden), 32'd0);
        check({tag, ".wrden"}, 32'(fc_weight_rden), 32'd0);
        check({tag, ".clr"},   32'(addr_clear),     32'd0);
        check({tag, ".aen"},   32'(addr_en),        32'd0);
        check({tag, ".en"},    32'(enable_mult),    32'd0);
        check({tag, ".acc"},   32'(accum_sload),    32'd0);
        check({tag, ".wr"},    32'(write_en),       32'd0);
        check({tag, ".busy"},  32'(busy),           32'd0);
        check({tag, ".done"},  32'(done),           32'd0);
        check({tag, ".cs"},    32'(count_sload),    32'd0);
        check({tag, ".co"},    32'(count_out),      32'd0);
        check({tag, ".ma"},    32'(ma),             32'd0);
        check({tag, ".mb"},    32'(mb),             32'd0);
    endtask

    task automatic run_table(input string tag, input vec_t tbl[NROWS]);
        vec_t  e;
        string nm;
        for (int i = 0; i < NROWS; i++) begin
            start = tbl[i].start;
            hold  = tbl[i].hold;
            sb_q.push_back(tbl[i]);
            @(posedge clock);
            #1;
            e  = sb_q.pop_front();
            nm = $sformatf("%s[%0d]", tag, i);
            check({nm, ".rden"},  32'(in_neuron_rden), 32'(e.rden));
            check({nm, ".wrden"}, 32'(fc_weight_rden), 32'(e.rden));
            check({nm, ".aen"},   32'(addr_en),        32'(e.rden));
            check({nm, ".clr"},   32'(addr_clear),     32'(e.clr));
            check({nm, ".en"},    32'(enable_mult),    32'(e.en));
            check({nm, ".acc"},   32'(accum_sload),    32'(e.acc));
            check({nm, ".wr"},    32'(write_en),       32'(e.wr));
            check({nm, ".done"},  32'(done),           32'(e.done));
            check({nm, ".busy"},  32'(busy),           32'(e.busy));
            check({nm, ".cs"},    32'(count_sload),    32'(e.cs));
            check({nm, ".co"},    32'(count_out),      32'(e.co));
            check({nm, ".ma"},    32'(ma),             32'(e.ma));
            check({nm, ".mb"},    32'(mb),             32'(e.mb));
        end
        start = 1'b0;
        hold  = 1'b0;
    endtask

    initial begin
        int beats;
        reset_n = 1'b0;
        start   = 1'b0;
        hold    = 1'b0;
        start3  = 1'b0;
        qa_all  = {16'h0022, 16'h0011};
        qb_all  = {16'h0044, 16'h0033};
        qa3     = 16'h00A5;
        qb3     = 16'h005A;

        for (int i = 0; i < NROWS; i++) begin
            nom_tbl[i]        = nominal(i);
            nom_tbl[i].start  = (i == 0);
            rst_tbl[i]        = nom_tbl[i];
            rst_tbl[i].start  = (i == 0) || (i == 3);
            hold_tbl[i]       = hold_vec(i);
            hold_tbl[i].start = (i == 0);
            hold_tbl[i].hold  = (i == 2) || (i == 3);
        end

        #12;
        check_zero("in_reset");
        @(negedge clock);
        reset_n = 1'b1;
        @(posedge clock);
        #1;
        check_zero("idle");

        run_table("nominal", nom_tbl);
        run_table("restart_from_done", rst_tbl);
        run_table("hold", hold_tbl);

        // Asynchronous reset in the middle of a run
        start = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
        repeat (4) @(posedge clock);
        #2;
        reset_n = 1'b0;
        #1;
        check_zero("async_reset");
        @(negedge clock);
        reset_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(posedge clock);
            #1;
            check($sformatf("post_reset[%0d].wr", i),   32'(write_en), 32'd0);
            check($sformatf("post_reset[%0d].done", i), 32'(done),     32'd0);
            check($sformatf("post_reset[%0d].busy", i), 32'(busy),     32'd0);
        end
        run_table("after_reset", nom_tbl);

        // RD_LATENCY=3, PI=1, K=3: sload at 3/6, write_en at 6/9, done at 10
        beats  = 0;
        start3 = 1'b1;
        for (int n = 0; n <= 12; n++) begin
            bit exp_en;
            @(posedge clock);
            #1;
            start3 = 1'b0;
            exp_en = (n >= 3 && n <= 8);
            if (en3) beats++;
            check($sformatf("lat3[%0d].en", n),   32'(en3),   32'(exp_en));
            check($sformatf("lat3[%0d].acc", n),  32'(acc3),  32'((n == 3) || (n == 6)));
            check($sformatf("lat3[%0d].wr", n),   32'(wr3),   32'((n == 6) || (n == 9)));
            check($sformatf("lat3[%0d].done", n), 32'(done3), 32'(n >= 10));
            check($sformatf("lat3[%0d].busy", n), 32'(busy3), 32'(n <= 9));
            check($sformatf("lat3[%0d].rden", n), 32'(rden3), 32'(n <= 5));
            check($sformatf("lat3[%0d].ma", n),   32'(ma3),   exp_en ? 32'h00A5 : 32'h0);
            check($sformatf("lat3[%0d].mb", n),   32'(mb3),   exp_en ? 32'h005A : 32'h0);
        end
        check("lat3.beat_count", 32'(beats), 32'd6);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
